dmem_io_bridge: RTL

Sits between the processor's data-memory port and the dmem block; runs on the fast `clock` domain shared with dmem.
- Addresses 0x000–0xEFF pass through to dmem unchanged.
- Addresses 0xF00–0xFFF decode to memory-mapped I/O: an 8-deep byte TX FIFO feeding a serial transmitter, an LED register and a free-running cycle counter.
- Read data returns with the same one-clock latency as dmem, so the processor sees a uniform memory.

---
 rtl/io_map_pkg.sv | 25 ++
 rtl/tx_serializer.sv | 99 +++++++++
 rtl/dmem_io_bridge.sv | 123 ++++++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// Shared constants for the data-memory I/O bridge: I/O window, register
// offsets, STATUS bit positions and transmitter state encoding.
package io_map_pkg;

  localparam logic [3:0] IO_BASE = 4'hF;

  localparam logic [7:0] OFS_TXDATA = 8'h00;
  localparam logic [7:0] OFS_STATUS = 8'h01;
  localparam logic [7:0] OFS_LED    = 8'h02;
  localparam logic [7:0] OFS_CYCLES = 8'h03;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tx_serializer.sv
// Byte-wide serial transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit,
// each BAUD_DIV clocks long, driven from a valid/ready byte interface.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   TX_IDLE  | line high, ready for a byte
//   TX_START | line low for one bit time
//   TX_DATA  | shifting out data bits, LSB first
//   TX_STOP  | line high for one bit time, then back to idle
module tx_serializer
  import io_map_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx_serial,
  output logic       busy
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_LOAD = CW'(BAUD_DIV - 1);

  tx_state_t     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
    end
  end

  // bit timer counts down and advances on terminal count
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    byte_ready = 1'b0;
    case (state)
      TX_IDLE: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_d = TX_START;
          cnt_d   = BIT_LOAD;
          shreg_d = byte_data;
        end
      end
      TX_START: begin
        if (cnt == '0) begin
          state_d   = TX_DATA;
          cnt_d     = BIT_LOAD;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt == '0) begin
          cnt_d   = BIT_LOAD;
          shreg_d = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_d = TX_STOP;
          else bit_idx_d = bit_idx + 3'd1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt == '0) state_d = TX_IDLE;
        else cnt_d = cnt - 1'b1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    case (state)
      TX_START: tx_serial = 1'b0;
      TX_DATA:  tx_serial = shreg[0];
      default:  tx_serial = 1'b1;
    endcase
  end

  assign busy = (state != TX_IDLE);

endmodule

// File: rtl/dmem_io_bridge.sv
// Data-memory bridge: passes 0x000-0xEFF to dmem, decodes 0xF00-0xFFF to TX FIFO,
// LED and status registers. Optional cycle counter at 0xF03 via DMEM_IO_CYCLE_COUNTER_EN.
module dmem_io_bridge
  import io_map_pkg::*;
#(
  parameter int DMEM_AW    = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               proc_tick,
  input  logic [DMEM_AW-1:0] address_in,
  input  logic [31:0]        data_in,
  input  logic               wren_in,
  output logic [31:0]        q_out,
  output logic [DMEM_AW-1:0] address_dmem,
  output logic [31:0]        data_dmem,
  output logic               wren_dmem,
  input  logic [31:0]        q_dmem,
  output logic               tx_serial,
  output logic [7:0]         led
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic          io_sel, io_sel_q, armed, io_wr;
  logic [7:0]    ofs;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_count;
  logic          full, empty, push_req, push, pop, overflow;
  logic          tx_ready, tx_busy;
  logic [31:0]   status, cycles_rd, io_rdata_d, io_rdata_q;

  assign io_sel       = (address_in[DMEM_AW-1 -: 4] == IO_BASE);
  assign ofs          = address_in[7:0];
  assign address_dmem = address_in;
  assign data_dmem    = data_in;
  assign wren_dmem    = wren_in & ~io_sel;

  // wren_in spans several fast clocks; armed limits I/O side effects to one per processor cycle
  assign io_wr    = wren_in & io_sel & armed;
  assign full     = (fifo_count == (PW+1)'(FIFO_DEPTH));
  assign empty    = (fifo_count == '0);
  assign push_req = io_wr && (ofs == OFS_TXDATA);
  assign pop      = tx_ready & ~empty;
  assign push     = push_req & (~full | pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed      <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      led        <= '0;
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      if (proc_tick) armed <= 1'b1;
      else if (io_wr) armed <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push_req & full & ~pop) overflow <= 1'b1;
      else if (io_wr && (ofs == OFS_STATUS)) overflow <= 1'b0;
      if (io_wr && (ofs == OFS_LED)) led <= data_in[7:0];
      io_sel_q   <= io_sel;
      io_rdata_q <= io_rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= data_in[7:0];
  end

`ifdef DMEM_IO_CYCLE_COUNTER_EN
  logic [31:0] cycles;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycles <= '0;
    else cycles <= cycles + 32'd1;
  end
  assign cycles_rd = cycles;
`else
  assign cycles_rd = '0;
`endif

  always_comb begin
    status                     = '0;
    status[ST_FULL]            = full;
    status[ST_EMPTY]           = empty;
    status[ST_BUSY]            = tx_busy;
    status[ST_OVF]             = overflow;
    status[ST_COUNT_LSB +: 4]  = 4'(fifo_count);
  end

  always_comb begin
    case (ofs)
      OFS_TXDATA, OFS_STATUS: io_rdata_d = status;
      OFS_LED:                io_rdata_d = {24'b0, led};
      OFS_CYCLES:             io_rdata_d = cycles_rd;
      default:                io_rdata_d = '0;
    endcase
  end

  assign q_out = io_sel_q ? io_rdata_q : q_dmem;

  tx_serializer #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clock      (clock),
    .reset      (reset),
    .byte_data  (fifo_mem[rd_ptr]),
    .byte_valid (~empty),
    .byte_ready (tx_ready),
    .tx_serial  (tx_serial),
    .busy       (tx_busy)
  );

endmodule
